// File: rtl/fu_cdb_select.sv
// Complete-stage arbiter: grants up to NUM_CDB prepared FU results per cycle with a
// rotating priority and registers the winners onto the CDB and ROB completion ports.
package fu_cdb_select_pkg;
    localparam int XLEN   = 32;
    localparam int PRN_W  = 6;
    localparam int ROBN_W = 5;

    typedef logic [ROBN_W-1:0] robn_t;

    typedef struct packed {
        robn_t             robn;
        logic [PRN_W-1:0]  dest_prn;
        logic [XLEN-1:0]   result;
    } fu_state_basic_packet_t;

    typedef struct packed {
        fu_state_basic_packet_t basic;
        logic                   take_branch;
        logic [XLEN-1:0]        target_pc;
    } fu_state_alu_packet_t;

    typedef struct packed {
        logic [PRN_W-1:0] dest_prn;
        logic [XLEN-1:0]  value;
    } cdb_packet_t;
endpackage

module fu_cdb_select
    import fu_cdb_select_pkg::*;
#(
    parameter int NUM_ALU  = 3,
    parameter int NUM_MULT = 2,
    parameter int NUM_LOAD = 1,
    parameter int NUM_CDB  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   squash,
    input  logic [NUM_ALU-1:0]     alu_prepared,
    input  fu_state_alu_packet_t   alu_packet [NUM_ALU],
    input  logic [NUM_MULT-1:0]    mult_prepared,
    input  fu_state_basic_packet_t mult_packet [NUM_MULT],
    input  logic [NUM_LOAD-1:0]    load_prepared,
    input  fu_state_basic_packet_t load_packet [NUM_LOAD],
    output logic [NUM_ALU-1:0]     alu_avail,
    output logic [NUM_MULT-1:0]    mult_avail,
    output logic [NUM_LOAD-1:0]    load_avail,
    output logic [NUM_CDB-1:0]     cdb_valid,
    output cdb_packet_t            cdb_packet [NUM_CDB],
    output logic [NUM_CDB-1:0]     rob_done_valid,
    output robn_t                  rob_done_robn [NUM_CDB]
);

    localparam int NUM_REQ = NUM_ALU + NUM_MULT + NUM_LOAD;
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     avail;
    fu_state_basic_packet_t req_pkt [NUM_REQ];

    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       slot_src [NUM_CDB];
    logic [NUM_CDB-1:0]     slot_vld;

    logic [NUM_CDB-1:0]     cdb_valid_q, cdb_valid_d;
    logic [NUM_CDB-1:0]     rob_done_valid_q, rob_done_valid_d;
    cdb_packet_t            cdb_packet_q [NUM_CDB];
    cdb_packet_t            cdb_packet_d [NUM_CDB];
    robn_t                  rob_done_robn_q [NUM_CDB];
    robn_t                  rob_done_robn_d [NUM_CDB];

    logic                   unused_alu_fields;

    assign req = {load_prepared, mult_prepared, alu_prepared};

    always_comb begin
        for (int i = 0; i < NUM_ALU; i++) begin
            req_pkt[i] = alu_packet[i].basic;
        end
        for (int i = 0; i < NUM_MULT; i++) begin
            req_pkt[NUM_ALU + i] = mult_packet[i];
        end
        for (int i = 0; i < NUM_LOAD; i++) begin
            req_pkt[NUM_ALU + NUM_MULT + i] = load_packet[i];
        end
    end

    always_comb begin
        unused_alu_fields = 1'b0;
        for (int i = 0; i < NUM_ALU; i++) begin
            unused_alu_fields = unused_alu_fields ^ alu_packet[i].take_branch ^ (^alu_packet[i].target_pc);
        end
    end

    // Rotating scan from ptr; winners fill CDB slots in scan order.
    always_comb begin
        int idx;
        int cnt;
        int last;
        grant    = '0;
        slot_vld = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            slot_src[k] = '0;
        end
        idx  = 0;
        cnt  = 0;
        last = int'(ptr_q);
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (req[idx] && (cnt < NUM_CDB)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (k == cnt) begin
                        slot_vld[k] = 1'b1;
                        slot_src[k] = PTR_W'(idx);
                    end
                end
                cnt  = cnt + 1;
                last = idx;
            end
        end
        ptr_d = (cnt > 0) ? PTR_W'((last + 1) % NUM_REQ) : ptr_q;
    end

    assign avail      = ~req | grant;
    assign alu_avail  = avail[NUM_ALU-1:0];
    assign mult_avail = avail[NUM_ALU +: NUM_MULT];
    assign load_avail = avail[NUM_ALU + NUM_MULT +: NUM_LOAD];

    // A squash still consumes the granted results but publishes nothing.
    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_valid_d[k]      = slot_vld[k] & ~squash;
            rob_done_valid_d[k] = slot_vld[k] & ~squash;
            cdb_packet_d[k]     = '0;
            rob_done_robn_d[k]  = '0;
            if (slot_vld[k] && !squash) begin
                cdb_packet_d[k].dest_prn = req_pkt[slot_src[k]].dest_prn;
                cdb_packet_d[k].value    = req_pkt[slot_src[k]].result;
                rob_done_robn_d[k]       = req_pkt[slot_src[k]].robn;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q            <= '0;
            cdb_valid_q      <= '0;
            rob_done_valid_q <= '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_packet_q[k]    <= '0;
                rob_done_robn_q[k] <= '0;
            end
        end else begin
            ptr_q            <= ptr_d;
            cdb_valid_q      <= cdb_valid_d;
            rob_done_valid_q <= rob_done_valid_d;
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_packet_q[k]    <= cdb_packet_d[k];
                rob_done_robn_q[k] <= rob_done_robn_d[k];
            end
        end
    end

    assign cdb_valid      = cdb_valid_q;
    assign rob_done_valid = rob_done_valid_q;
    assign cdb_packet     = cdb_packet_q;
    assign rob_done_robn  = rob_done_robn_q;

endmodule
